// File: rtl/uart_bus_responder_pkg.sv
// Shared definitions for the memory-mapped UART responder: register offsets,
// STATUS bit positions, serializer/receiver state encodings and frame shape.
package uart_bus_responder_pkg;

  // Register select values taken from HADDR[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_RXDATA = 2'd2;
  localparam logic [1:0] REG_BAUD   = 2'd3;

  // STATUS register bit positions
  localparam int ST_TX_FULL     = 0;
  localparam int ST_TX_EMPTY    = 1;
  localparam int ST_TX_BUSY     = 2;
  localparam int ST_RX_VALID    = 3;
  localparam int ST_RX_OVERRUN  = 4;
  localparam int ST_TX_OVERFLOW = 5;
  localparam int ST_FRAMING_ERR = 6;
  localparam int STATUS_BITS    = 7;

  // 8N1 frame: start + 8 data + stop
  localparam int FRAME_BITS = 10;
  localparam logic [2:0] LAST_DATA_BIT = 3'(FRAME_BITS - 3);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } txState_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rxState_t;

  // A programmed divisor of zero is treated as one clock per bit
  function automatic logic [15:0] effectiveDiv(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO. A push while full is accepted only when a pop happens
// in the same cycle; pops on an empty FIFO are ignored.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           popData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wrPtr_r;
  logic [AW-1:0]    rdPtr_r;
  logic [AW:0]      count_r;
  logic             pushOk_s;
  logic             popOk_s;

  assign full     = (count_r == FULL_COUNT);
  assign empty    = (count_r == {(AW+1){1'b0}});
  assign count    = count_r;
  assign popData  = mem_r[rdPtr_r];
  assign popOk_s  = pop && !empty;
  assign pushOk_s = push && (!full || popOk_s);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock) begin
    if (!reset) begin
      wrPtr_r <= {AW{1'b0}};
      rdPtr_r <= {AW{1'b0}};
      count_r <= {(AW+1){1'b0}};
    end else begin
      if (pushOk_s) wrPtr_r <= wrPtr_r + AW'(1);
      if (popOk_s)  rdPtr_r <= rdPtr_r + AW'(1);
      case ({pushOk_s, popOk_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clock) begin
    if (pushOk_s) mem_r[wrPtr_r] <= pushData;
  end

endmodule

// File: rtl/uart_bus_responder.sv
// UART peripheral on the core's data bus. Reads are combinational, writes
// land on the clock edge. TXDATA writes feed a FIFO drained by an 8N1
// serializer. Define UART_RX_EN to build the receiver (rx port, RXDATA and
// STATUS bits 3/4/6); without it those read as zero.
module uart_bus_responder
  import uart_bus_responder_pkg::*;
#(
  parameter int                LENGTH      = 32,
  parameter logic [LENGTH-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter int                FIFO_DEPTH  = 8,
  parameter logic [15:0]       DEFAULT_DIV = 16'd434
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [LENGTH-1:0] HADDR,
  input  logic [LENGTH-1:0] HWDATA,
  input  logic              MemWrite,
  output logic [LENGTH-1:0] HRDATA,
  output logic              tx
`ifdef UART_RX_EN
  ,
  input  logic              rx
`endif
);
  logic                      select_s, pushTx_s, wrStatus_s, wrBaud_s;
  logic [1:0]                regSel_s;
  logic [15:0]               div_r, effDiv_s;
  logic                      txOvf_r, txOvfSet_s;
  logic                      fifoFull_s, fifoEmpty_s, txPop_s;
  logic [7:0]                fifoData_s;
  logic [$clog2(FIFO_DEPTH):0] fifoCount_s;
  txState_t                  txState_r, txStateNext_s;
  logic [15:0]               txTimer_r, txTimerNext_s;
  logic [2:0]                txBit_r, txBitNext_s;
  logic [7:0]                txShift_r, txShiftNext_s;
  logic                      txNext_s;
  logic [STATUS_BITS-1:0]    statusVec_s;
  logic [LENGTH-1:0]         readData_s;
  logic                      rxValidBit_s, rxOverrunBit_s, framingBit_s;
  logic [7:0]                rxByteOut_s;
  logic                      unusedBits_s;

  assign select_s   = (HADDR[LENGTH-1:4] == BASE_ADDR[LENGTH-1:4]);
  assign regSel_s   = HADDR[3:2];
  assign pushTx_s   = select_s && MemWrite && (regSel_s == REG_TXDATA);
  assign wrStatus_s = select_s && MemWrite && (regSel_s == REG_STATUS);
  assign wrBaud_s   = select_s && MemWrite && (regSel_s == REG_BAUD);
  assign effDiv_s   = effectiveDiv(div_r);
  assign txOvfSet_s = pushTx_s && fifoFull_s && !txPop_s;
  assign unusedBits_s = &{1'b0, HWDATA[LENGTH-1:16], HADDR[1:0], fifoCount_s};

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) txFifo (
    .clock    (clock),
    .reset    (reset),
    .push     (pushTx_s),
    .pushData (HWDATA[7:0]),
    .pop      (txPop_s),
    .popData  (fifoData_s),
    .full     (fifoFull_s),
    .empty    (fifoEmpty_s),
    .count    (fifoCount_s)
  );

  // Baud divisor and sticky TX overflow flag (set beats W1C)
  always_ff @(posedge clock) begin
    if (!reset) begin
      div_r   <= DEFAULT_DIV;
      txOvf_r <= 1'b0;
    end else begin
      if (wrBaud_s) div_r <= HWDATA[15:0];
      txOvf_r <= txOvfSet_s ? 1'b1
               : ((wrStatus_s && HWDATA[ST_TX_OVERFLOW]) ? 1'b0 : txOvf_r);
    end
  end

  // Serializer next state: bit timer reloads from the divisor at every boundary
  always_comb begin
    txStateNext_s = txState_r;
    txTimerNext_s = txTimer_r;
    txBitNext_s   = txBit_r;
    txShiftNext_s = txShift_r;
    txPop_s       = 1'b0;
    case (txState_r)
      TX_IDLE: begin
        if (!fifoEmpty_s) begin
          txPop_s       = 1'b1;
          txStateNext_s = TX_START;
          txTimerNext_s = effDiv_s;
          txShiftNext_s = fifoData_s;
        end else begin
          txStateNext_s = TX_IDLE;
        end
      end
      TX_START: begin
        if (txTimer_r == 16'd1) begin
          txStateNext_s = TX_DATA;
          txTimerNext_s = effDiv_s;
          txBitNext_s   = 3'd0;
        end else begin
          txTimerNext_s = txTimer_r - 16'd1;
        end
      end
      TX_DATA: begin
        if (txTimer_r == 16'd1) begin
          txTimerNext_s = effDiv_s;
          if (txBit_r == LAST_DATA_BIT) begin
            txStateNext_s = TX_STOP;
          end else begin
            txBitNext_s   = txBit_r + 3'd1;
            txShiftNext_s = {1'b0, txShift_r[7:1]};
          end
        end else begin
          txTimerNext_s = txTimer_r - 16'd1;
        end
      end
      TX_STOP: begin
        if (txTimer_r == 16'd1) begin
          if (!fifoEmpty_s) begin
            txPop_s       = 1'b1;
            txStateNext_s = TX_START;
            txTimerNext_s = effDiv_s;
            txShiftNext_s = fifoData_s;
          end else begin
            txStateNext_s = TX_IDLE;
          end
        end else begin
          txTimerNext_s = txTimer_r - 16'd1;
        end
      end
      default: txStateNext_s = TX_IDLE;
    endcase
  end

  // Line level for the state being entered, so tx is a clean register output
  always_comb begin
    case (txStateNext_s)
      TX_START: txNext_s = 1'b0;
      TX_DATA:  txNext_s = txShiftNext_s[0];
      default:  txNext_s = 1'b1;
    endcase
  end

  // Serializer registers; reset aborts any frame and idles the line high
  always_ff @(posedge clock) begin
    if (!reset) begin
      txState_r <= TX_IDLE;
      txTimer_r <= 16'd0;
      txBit_r   <= 3'd0;
      txShift_r <= 8'd0;
      tx        <= 1'b1;
    end else begin
      txState_r <= txStateNext_s;
      txTimer_r <= txTimerNext_s;
      txBit_r   <= txBitNext_s;
      txShift_r <= txShiftNext_s;
      tx        <= txNext_s;
    end
  end

`ifdef UART_RX_EN
  logic        rxMeta_r, rxSync_r;
  rxState_t    rxState_r, rxStateNext_s;
  logic [15:0] rxTimer_r, rxTimerNext_s, halfDiv_s;
  logic [2:0]  rxBit_r, rxBitNext_s;
  logic [7:0]  rxShift_r, rxShiftNext_s, rxByte_r;
  logic        rxValid_r, rxOverrun_r, frameErr_r, rxDone_s, rxBad_s;

  assign halfDiv_s = (effDiv_s[15:1] == 15'd0) ? 16'd1 : {1'b0, effDiv_s[15:1]};

  // Two-flop synchronizer for the asynchronous serial input
  always_ff @(posedge clock) begin
    if (!reset) begin
      rxMeta_r <= 1'b1;
      rxSync_r <= 1'b1;
    end else begin
      rxMeta_r <= rx;
      rxSync_r <= rxMeta_r;
    end
  end

  // Receiver next state: confirm start at half-bit, then sample at mid-bit
  always_comb begin
    rxStateNext_s = rxState_r;
    rxTimerNext_s = rxTimer_r;
    rxBitNext_s   = rxBit_r;
    rxShiftNext_s = rxShift_r;
    rxDone_s      = 1'b0;
    rxBad_s       = 1'b0;
    case (rxState_r)
      RX_IDLE: begin
        if (!rxSync_r) begin
          rxStateNext_s = RX_START;
          rxTimerNext_s = halfDiv_s;
        end else begin
          rxStateNext_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (rxTimer_r == 16'd1) begin
          if (!rxSync_r) begin
            rxStateNext_s = RX_DATA;
            rxTimerNext_s = effDiv_s;
            rxBitNext_s   = 3'd0;
          end else begin
            rxStateNext_s = RX_IDLE;
          end
        end else begin
          rxTimerNext_s = rxTimer_r - 16'd1;
        end
      end
      RX_DATA: begin
        if (rxTimer_r == 16'd1) begin
          rxShiftNext_s = {rxSync_r, rxShift_r[7:1]};
          rxTimerNext_s = effDiv_s;
          if (rxBit_r == LAST_DATA_BIT) begin
            rxStateNext_s = RX_STOP;
          end else begin
            rxBitNext_s = rxBit_r + 3'd1;
          end
        end else begin
          rxTimerNext_s = rxTimer_r - 16'd1;
        end
      end
      RX_STOP: begin
        if (rxTimer_r == 16'd1) begin
          if (rxSync_r) begin
            rxDone_s = 1'b1;
          end else begin
            rxBad_s = 1'b1;
          end
          rxStateNext_s = RX_IDLE;
        end else begin
          rxTimerNext_s = rxTimer_r - 16'd1;
        end
      end
      default: rxStateNext_s = RX_IDLE;
    endcase
  end

  // Receiver registers and sticky RX flags (set beats W1C)
  always_ff @(posedge clock) begin
    if (!reset) begin
      rxState_r   <= RX_IDLE;
      rxTimer_r   <= 16'd0;
      rxBit_r     <= 3'd0;
      rxShift_r   <= 8'd0;
      rxByte_r    <= 8'd0;
      rxValid_r   <= 1'b0;
      rxOverrun_r <= 1'b0;
      frameErr_r  <= 1'b0;
    end else begin
      rxState_r <= rxStateNext_s;
      rxTimer_r <= rxTimerNext_s;
      rxBit_r   <= rxBitNext_s;
      rxShift_r <= rxShiftNext_s;
      if (rxDone_s) rxByte_r <= rxShift_r;
      rxValid_r   <= rxDone_s ? 1'b1
                   : ((wrStatus_s && HWDATA[ST_RX_VALID]) ? 1'b0 : rxValid_r);
      rxOverrun_r <= (rxDone_s && rxValid_r) ? 1'b1
                   : ((wrStatus_s && HWDATA[ST_RX_OVERRUN]) ? 1'b0 : rxOverrun_r);
      frameErr_r  <= rxBad_s ? 1'b1
                   : ((wrStatus_s && HWDATA[ST_FRAMING_ERR]) ? 1'b0 : frameErr_r);
    end
  end

  assign rxValidBit_s   = rxValid_r;
  assign rxOverrunBit_s = rxOverrun_r;
  assign framingBit_s   = frameErr_r;
  assign rxByteOut_s    = rxByte_r;
`else
  assign rxValidBit_s   = 1'b0;
  assign rxOverrunBit_s = 1'b0;
  assign framingBit_s   = 1'b0;
  assign rxByteOut_s    = 8'd0;
`endif

  // STATUS register image
  always_comb begin
    statusVec_s = {STATUS_BITS{1'b0}};
    statusVec_s[ST_TX_FULL]     = fifoFull_s;
    statusVec_s[ST_TX_EMPTY]    = fifoEmpty_s;
    statusVec_s[ST_TX_BUSY]     = (txState_r != TX_IDLE);
    statusVec_s[ST_RX_VALID]    = rxValidBit_s;
    statusVec_s[ST_RX_OVERRUN]  = rxOverrunBit_s;
    statusVec_s[ST_TX_OVERFLOW] = txOvf_r;
    statusVec_s[ST_FRAMING_ERR] = framingBit_s;
  end

  // Zero-latency read mux; unselected addresses read zero
  always_comb begin
    readData_s = {LENGTH{1'b0}};
    if (select_s) begin
      case (regSel_s)
        REG_TXDATA: readData_s = {LENGTH{1'b0}};
        REG_STATUS: readData_s[STATUS_BITS-1:0] = statusVec_s;
        REG_RXDATA: readData_s[7:0] = rxByteOut_s;
        REG_BAUD:   readData_s[15:0] = div_r;
        default:    readData_s = {LENGTH{1'b0}};
      endcase
    end else begin
      readData_s = {LENGTH{1'b0}};
    end
  end

  assign HRDATA = readData_s;

endmodule

// File: tb/tb_uart_bus_responder.sv
// Scoreboard bench for uart_bus_responder: stimulus queues expected values,
// a negedge monitor pops and compares them against HRDATA / tx.
`timescale 1ns/1ps
module tb_uart_bus_responder;

  localparam logic [31:0] A_TX   = 32'h1000_0000;
  localparam logic [31:0] A_ST   = 32'h1000_0004;
  localparam logic [31:0] A_RX   = 32'h1000_0008;
  localparam logic [31:0] A_BAUD = 32'h1000_000C;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] HADDR = 32'd0;
  logic [31:0] HWDATA = 32'd0;
  logic        MemWrite = 1'b0;
  logic [31:0] HRDATA;
  logic        tx;
`ifdef UART_RX_EN
  logic        rx = 1'b1;
`endif

  always #5 clock = ~clock;

  uart_bus_responder dut (
    .clock    (clock),
    .reset    (reset),
    .HADDR    (HADDR),
    .HWDATA   (HWDATA),
    .MemWrite (MemWrite),
    .HRDATA   (HRDATA),
    .tx       (tx)
`ifdef UART_RX_EN
    ,
    .rx       (rx)
`endif
  );

  typedef struct {
    bit          isTx;
    string       name;
    logic [31:0] exp;
  } expect_t;

  expect_t sbQ[$];
  bit      sampleReq = 1'b0;
  int      checks = 0;
  int      errors = 0;

  // Monitor: on a sample request, drain every queued expectation
  always @(negedge clock) begin : monitor
    expect_t     e;
    logic [31:0] act;
    if (sampleReq) begin
      while (sbQ.size() > 0) begin
        e   = sbQ.pop_front();
        act = e.isTx ? {31'd0, tx} : HRDATA;
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expTx(input logic v, input string n);
    expect_t e;
    e.isTx = 1'b1; e.name = n; e.exp = {31'd0, v};
    sbQ.push_back(e);
  endtask

  task automatic expRd(input logic [31:0] addr, input logic [31:0] v, input string n);
    expect_t e;
    HADDR = addr;
    e.isTx = 1'b0; e.name = n; e.exp = v;
    sbQ.push_back(e);
  endtask

  task automatic sample();
    sampleReq = 1'b1;
    @(negedge clock);
    #1;
    sampleReq = 1'b0;
  endtask

  task automatic checkRd(input logic [31:0] addr, input logic [31:0] v, input string n);
    expRd(addr, v, n);
    sample();
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    HADDR = addr; HWDATA = data; MemWrite = 1'b1;
    step();
    MemWrite = 1'b0;
  endtask

  // Expected line level c cycles after START for a single frame of divisor d
  function automatic logic txBitAt(input int c, input logic [7:0] b, input int d);
    int pos;
    if (c < 0) return 1'b1;
    pos = c / d;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    return 1'b1;
  endfunction

  // Start and bit0 at 4 cycles, then divisor 8 from bit1 on
  function automatic logic txBaudChange(input int c, input logic [7:0] b);
    if (c < 0) return 1'b1;
    if (c < 4) return 1'b0;
    if (c < 8) return b[0];
    if (c < 64) return b[1 + (c - 8) / 8];
    return 1'b1;
  endfunction

`ifdef UART_RX_EN
  task automatic rxSend(input logic [7:0] b, input logic stopBit);
    rx = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (4) step();
    end
    rx = stopBit;
    repeat (4) step();
    rx = 1'b1;
    repeat (12) step();
  endtask
`endif

  logic [7:0] burst [10];
  int         c;

  initial begin
    // Reset state
    repeat (3) step();
    reset = 1'b1;
    step();
    expTx(1'b1, "reset_tx_idle");
    expRd(A_ST, 32'h02, "reset_status");
    sample();
    checkRd(A_BAUD, 32'd434, "reset_baud");
    checkRd(A_RX, 32'd0, "reset_rxdata");
    checkRd(A_TX, 32'd0, "txdata_reads_zero");
    checkRd(32'h2000_0004, 32'd0, "unselected_read");
    wr(32'h2000_000C, 32'd5);
    checkRd(A_BAUD, 32'd434, "unselected_write_ignored");

    // Single frame at div=4
    wr(A_BAUD, 32'd4);
    checkRd(A_BAUD, 32'd4, "baud_div4");
    wr(A_TX, 32'h55);
    expTx(1'b1, "tx_high_one_edge_after_write");
    sample();
    for (int k = 0; k < 40; k++) begin
      step();
      expTx(txBitAt(k, 8'h55, 4), $sformatf("tx55_c%0d", k));
      if (k == 39) expRd(A_ST, 32'h06, "status_busy_in_stop");
      sample();
    end
    step();
    expTx(1'b1, "tx_idle_after_frame");
    expRd(A_ST, 32'h02, "status_busy_cleared");
    sample();

    // Ten back-to-back writes at div=2: nine sent, one dropped
    wr(A_BAUD, 32'd2);
    for (int i = 0; i < 10; i++) burst[i] = 8'h30 + 8'(i * 7);
    for (int t = 0; t < 186; t++) begin
      if (t < 10) begin
        HADDR = A_TX; HWDATA = {24'd0, burst[t]}; MemWrite = 1'b1;
      end
      step();
      MemWrite = 1'b0;
      c = t - 1;
      if (c < 0) expTx(1'b1, "burst_pre_start");
      else if (c / 20 < 9) expTx(txBitAt(c % 20, burst[c / 20], 2), $sformatf("burst_c%0d", c));
      else expTx(1'b1, $sformatf("burst_idle_c%0d", c));
      if (t == 9) expRd(A_ST, 32'h25, "status_full_overflow");
      sample();
    end
    checkRd(A_ST, 32'h22, "overflow_sticky");
    wr(A_ST, 32'h20);
    checkRd(A_ST, 32'h02, "overflow_w1c");

    // Divisor change mid-bit takes effect at the next boundary
    wr(A_BAUD, 32'd4);
    for (int t = 0; t < 81; t++) begin
      if (t == 0) begin
        HADDR = A_TX; HWDATA = 32'h35; MemWrite = 1'b1;
      end else if (t == 7) begin
        HADDR = A_BAUD; HWDATA = 32'd8; MemWrite = 1'b1;
      end
      step();
      MemWrite = 1'b0;
      expTx(txBaudChange(t - 1, 8'h35), $sformatf("baudchg_c%0d", t - 1));
      sample();
    end
    wr(A_BAUD, 32'd4);

`ifdef UART_RX_EN
    // Receiver: good frame, overrun, framing error, W1C
    rxSend(8'hA3, 1'b1);
    checkRd(A_ST, 32'h0A, "rx_valid");
    checkRd(A_RX, 32'hA3, "rx_byte_a3");
    rxSend(8'h5C, 1'b1);
    checkRd(A_ST, 32'h1A, "rx_overrun");
    checkRd(A_RX, 32'h5C, "rx_byte_5c");
    rxSend(8'h77, 1'b0);
    checkRd(A_ST, 32'h5A, "rx_framing_err");
    checkRd(A_RX, 32'h5C, "rx_byte_kept");
    wr(A_ST, 32'h58);
    checkRd(A_ST, 32'h02, "rx_flags_w1c");
`else
    wr(A_ST, 32'h58);
    checkRd(A_ST, 32'h02, "rx_bits_absent");
    checkRd(A_RX, 32'd0, "rxdata_absent");
`endif

    // Reset in the middle of a data bit
    wr(A_TX, 32'h00);
    wr(A_TX, 32'h01);
    wr(A_TX, 32'h02);
    repeat (7) step();
    expTx(1'b0, "tx_low_mid_data");
    expRd(A_ST, 32'h04, "status_busy_before_reset");
    sample();
    reset = 1'b0;
    step();
    reset = 1'b1;
    expTx(1'b1, "tx_high_after_reset");
    expRd(A_ST, 32'h02, "status_after_reset");
    sample();
    checkRd(A_BAUD, 32'd434, "baud_after_reset");
    checkRd(A_RX, 32'd0, "rxdata_after_reset");
    for (int k = 0; k < 6; k++) begin
      step();
      expTx(1'b1, $sformatf("tx_stays_idle_%0d", k));
      sample();
    end
    checkRd(A_ST, 32'h02, "fifo_empty_after_reset");

    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
